// File: rtl/mem_copy_engine_pkg.sv
// Shared constants for the memory copy/fill engine.
// State encodings and command modes used by the engine and its bench.
package mem_copy_engine_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_copy_engine_ptr_unit.sv
// Source/destination pointers and remaining-word counter.
// Pointers wrap modulo 2^ADDR_W; last_word flags the final write.
module copy_ptr_unit #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] src_in,
    input  logic [ADDR_W-1:0] dst_in,
    input  logic [ADDR_W-1:0] len_in,
    input  logic              src_inc,
    input  logic              dst_inc,
    input  logic              cnt_dec,
    output logic [ADDR_W-1:0] src_ptr,
    output logic [ADDR_W-1:0] dst_ptr,
    output logic [ADDR_W-1:0] cnt,
    output logic              last_word
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_ptr <= '0;
            dst_ptr <= '0;
            cnt     <= '0;
        end else if (load) begin
            src_ptr <= src_in;
            dst_ptr <= dst_in;
            cnt     <= len_in;
        end else begin
            if (src_inc) src_ptr <= src_ptr + 1'b1;
            if (dst_inc) dst_ptr <= dst_ptr + 1'b1;
            if (cnt_dec) cnt     <= cnt - 1'b1;
        end
    end

    assign last_word = (cnt == ADDR_W'(1));

endmodule

// File: rtl/mem_copy_engine.sv
// Memory copy/fill bus initiator: copies LEN words SRC->DST or fills DST.
// All outputs decode from registered state so none depend on inputs.
module mem_copy_engine
    import mem_copy_engine_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] len,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic              mode_q;
    logic [DATA_W-1:0] fill_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [ADDR_W-1:0] cnt;
    logic              last_word;
    logic              accept;
    logic              in_rd;
    logic              in_wr;

    assign accept = (state == ST_IDLE) && start;
    assign in_rd  = (state == ST_RD);
    assign in_wr  = (state == ST_WR);

    copy_ptr_unit #(
        .ADDR_W (ADDR_W)
    ) u_ptr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .src_in    (src_addr),
        .dst_in    (dst_addr),
        .len_in    (len),
        .src_inc   (in_rd),
        .dst_inc   (in_wr),
        .cnt_dec   (in_wr),
        .src_ptr   (src_ptr),
        .dst_ptr   (dst_ptr),
        .cnt       (cnt),
        .last_word (last_word)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    if (len == '0)
                        state_nx = ST_DONE;
                    else if (mode == MODE_FILL)
                        state_nx = ST_WR;
                    else
                        state_nx = ST_RD;
                end
            end
            ST_RD:   state_nx = ST_WR;
            ST_WR: begin
                if (last_word)
                    state_nx = ST_DONE;
                else if (mode_q == MODE_FILL)
                    state_nx = ST_WR;
                else
                    state_nx = ST_RD;
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            mode_q <= MODE_COPY;
            fill_q <= '0;
            data_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                mode_q <= mode;
                fill_q <= fill_value;
            end
            if (in_rd)
                data_q <= mem_read_data;
        end
    end

    // Reset forces ST_IDLE asynchronously, which drops both strobes at once.
    always_comb begin
        mem_access_addr = '0;
        mem_write_data  = '0;
        mem_write_en    = 1'b0;
        mem_read        = 1'b0;
        if (in_rd) begin
            mem_read        = 1'b1;
            mem_access_addr = src_ptr;
        end else if (in_wr) begin
            mem_write_en    = 1'b1;
            mem_access_addr = dst_ptr;
            mem_write_data  = (mode_q == MODE_FILL) ? fill_q : data_q;
        end
    end

    assign busy = in_rd || in_wr;
    assign done = (state == ST_DONE);

endmodule
